avg_sched: RTL

- Shares one block-averaging datapath between NCH detector channels of the interferometer front end.
- Each channel streams signed samples with a valid/ready handshake. A round-robin arbiter grants one sample per cycle into that channel's accumulator.
- After 2^LOG2_N samples the block emits the channel mean on a single valid/ready output, tagged with the channel index. Downstream it feeds phase/density processing.

---
 rtl/avg_sched_pkg.sv | 30 +++
 rtl/avg_sched_rr_arbiter.sv | 47 ++++
 rtl/avg_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/avg_sched_pkg.sv
// Shared constants and helpers for the avg_sched block-averaging scheduler.
// Optional build macro used by the top: AVG_SCHED_SEQ_EN (per-channel window sequence tags).
package avg_sched_pkg;

  localparam int DW_DEF     = 16;
  localparam int LOG2_N_DEF = 8;
  localparam int ACC_W      = DW_DEF + LOG2_N_DEF;

  // Working width of the sign-extension helper; callers truncate to their own width.
  localparam int SEXT_W = 64;

  // Ceiling log2, never below 1 so a channel index always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Sign-extend the low w bits of v to SEXT_W bits.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int w);
    logic [SEXT_W-1:0] r;
    r = v;
    for (int b = 0; b < SEXT_W; b++) begin
      if (b >= w) r[b] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/avg_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// ptr moves to grant+1 on an advance strobe and is cleared by a synchronous clr.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  grant_idx
);

  logic [CW-1:0] ptr;

  // Priority search starting at ptr; only the first hit is granted.
  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CW'(idx);
      end
    end
  end

  // Pointer register: moves past the winner after each transfer, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == NCH - 1) ? '0 : CW'(grant_idx + 1'b1);
    end
  end

endmodule

// File: rtl/avg_sched.sv
// avg_sched: one block-averaging datapath shared round-robin between NCH channels.
// Each channel accumulates 2^LOG2_N signed samples; the floor mean is emitted on a
// single valid/ready output tagged with the channel index.
// Optional build macro AVG_SCHED_SEQ_EN adds m_seq, a per-channel window counter tag.
//
// Handshake: a beat moves when valid and ready are both high at the rising edge.
// s_ready is combinational from s_valid, the arbiter pointer and the block
// condition; m_valid holds with m_data/m_chan stable until m_ready is seen high.
module avg_sched
  import avg_sched_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DW     = DW_DEF,
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int CW     = clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    s_valid,
  input  logic [NCH*DW-1:0] s_data,
  output logic [NCH-1:0]    s_ready,
  input  logic              soft_clr,
  output logic              m_valid,
  output logic [DW-1:0]     m_data,
  output logic [CW-1:0]     m_chan,
  input  logic              m_ready
`ifdef AVG_SCHED_SEQ_EN
  ,
  output logic [7:0]        m_seq
`endif
);

  // Accumulator wide enough to hold a full window of extreme samples.
  localparam int AW = DW + LOG2_N;

  logic [AW-1:0]     acc [NCH];
  logic [LOG2_N-1:0] cnt [NCH];

  logic [NCH-1:0] blocked;
  logic [NCH-1:0] req;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  sel;
  logic           advance;
  logic [DW-1:0]  sample;
  logic [AW-1:0]  sum;
  logic           is_last;

  // A channel whose next sample closes its window must wait while the output is stuck.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      blocked[i] = (cnt[i] == {LOG2_N{1'b1}}) && m_valid && !m_ready;
    end
    req = (soft_clr || !rst_n) ? '0 : (s_valid & ~blocked);
  end

  rr_arbiter #(
    .NCH (NCH),
    .CW  (CW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (soft_clr),
    .req       (req),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (sel)
  );

  assign s_ready = grant;
  assign advance = |grant;

  // Datapath for the granted channel: its sample, running sum and window-close flag.
  always_comb begin
    sample  = s_data[int'(sel)*DW +: DW];
    sum     = acc[sel] + AW'(sext(SEXT_W'(sample), DW));
    is_last = (cnt[sel] == {LOG2_N{1'b1}});
  end

  // Per-channel accumulators and sample counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (soft_clr) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (advance) begin
      if (is_last) begin
        acc[sel] <= '0;
        cnt[sel] <= '0;
      end else begin
        acc[sel] <= sum;
        cnt[sel] <= cnt[sel] + 1'b1;
      end
    end
  end

  // Output register: loads on window completion, drops on a pop without a new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
    end else if (soft_clr) begin
      m_valid <= 1'b0;
    end else if (advance && is_last) begin
      m_valid <= 1'b1;
      m_data  <= sum[AW-1:LOG2_N];
      m_chan  <= sel;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef AVG_SCHED_SEQ_EN
  logic [7:0] seq [NCH];

  // Window sequence tags: the completing channel's count is published, then bumped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seq <= '0;
      for (int i = 0; i < NCH; i++) seq[i] <= '0;
    end else if (soft_clr) begin
      m_seq <= '0;
      for (int i = 0; i < NCH; i++) seq[i] <= '0;
    end else if (advance && is_last) begin
      m_seq    <= seq[sel];
      seq[sel] <= seq[sel] + 8'd1;
    end
  end
`endif

endmodule
